// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite ROM path.
package sprite_pkg;

  // Arbiter mode: free round-robin, or locked to one burst owner.
  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned SPRITE_ADDR_W = 10;
  localparam int unsigned SPRITE_DATA_W = 4;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PTR_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [PTR_W-1:0] idx;

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ and take the first hit.
  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick[idx]  = 1'b1;
        pick_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one synchronous sprite ROM.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = SPRITE_ADDR_W,
  parameter int unsigned DATA_W    = SPRITE_DATA_W,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t         state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [CNT_W-1:0]   burst_cnt_q;
  logic [NUM_REQ-1:0] tag_q [ROM_LAT];

  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [PTR_W-1:0]   ptr_after_pick;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // Winner's successor becomes highest priority next time; wraps for non-power-of-2 counts.
  assign ptr_after_pick = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);

  // Grant: round-robin pick when free, only the owner while locked.
  always_comb begin
    gnt = '0;
    if (state_q == BURST) begin
      gnt[owner_q] = req[owner_q];
    end else begin
      gnt = pick;
    end
  end

  // ROM address mux driven by the one-hot grant; zero when idle.
  always_comb begin
    rom_address = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) rom_address = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Arbitration FSM: pointer advance, burst lock and burst length bound.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (pick_valid) begin
            rr_ptr_q <= ptr_after_pick;
            if (req_lock[pick_idx]) begin
              state_q     <= BURST;
              owner_q     <= pick_idx;
              burst_cnt_q <= CNT_W'(1);
            end
          end
        end
        BURST: begin
          // Owner dropping req ends the burst with an idle ROM cycle.
          if (req[owner_q] && req_lock[owner_q] &&
              (burst_cnt_q < CNT_W'(MAX_BURST - 1))) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
          end else begin
            state_q     <= ARB;
            burst_cnt_q <= '0;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  // Grant tag pipeline matching ROM latency; reset drops reads in flight.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= gnt;
      for (int unsigned i = 1; i < ROM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign rd_valid = tag_q[ROM_LAT-1];
  assign rd_data  = rom_q;
  assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter with a behavioural arbitration model.
module tb_sprite_rom_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 4;
  localparam int unsigned LAT = 3;
  localparam int unsigned MB  = 8;

  logic              vga_clk  = 1'b0;
  logic              reset_n  = 1'b0;
  logic [N-1:0]      req      = '0;
  logic [N-1:0]      req_lock = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      gnt;
  logic [AW-1:0]     rom_address;
  logic [DW-1:0]     rom_q;
  logic [N-1:0]      rd_valid;
  logic [DW-1:0]     rd_data;
  logic              busy;

  sprite_rom_arbiter #(
    .NUM_REQ   (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ROM_LAT   (LAT),
    .MAX_BURST (MB)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .busy        (busy)
  );

  always #5 vga_clk = ~vga_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [N-1:0]  vec;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: owner -1 means no burst lock held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  logic [AW-1:0] addr [N];
  logic [N-1:0]  pend;
  logic [N-1:0]  lk;
  int            g;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ {a[9:8], a[1:0]};
  endfunction

  // Behavioural synchronous ROM with LAT cycles from address to data.
  logic [AW-1:0] apipe [LAT];
  always @(posedge vga_clk) begin
    apipe[0] <= rom_address;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign rom_q = rom_fn(apipe[LAT-1]);

  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle, either a due read returns or rd_valid must be quiet.
  always @(negedge vga_clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      chk("rd_valid", 64'(rd_valid), 64'(mon_e.vec));
      chk("rd_data", 64'(rd_data), 64'(mon_e.data));
    end else begin
      chk("rd_valid_idle", 64'(rd_valid), 64'(0));
    end
  end

  // One clock of stimulus: drive, predict grant from the model, check, push read.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, output int gi);
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    exp_t          e;
    int            idx;
    @(posedge vga_clk);
    #1;
    req      = r;
    req_lock = l;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
    @(negedge vga_clk);
    gi = -1;
    if (m_owner >= 0) begin
      if (r[m_owner]) gi = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gi < 0 && r[idx]) gi = idx;
      end
    end
    eg = '0;
    ea = '0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ea     = addr[gi];
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("rom_address", 64'(rom_address), 64'(ea));
    chk("busy", 64'(busy), 64'(m_owner >= 0));
    if (gi >= 0) begin
      e.vec  = eg;
      e.data = rom_fn(ea);
      e.due  = cyc + LAT;
      exp_q.push_back(e);
    end
    if (m_owner >= 0) begin
      if (gi < 0) begin
        m_owner = -1;
      end else begin
        m_cnt++;
        if (!l[m_owner] || m_cnt >= MB) m_owner = -1;
      end
    end else if (gi >= 0) begin
      m_ptr = (gi + 1) % N;
      if (l[gi]) begin
        m_owner = gi;
        m_cnt   = 1;
      end
    end
  endtask

  // Asynchronous reset pulse away from clock edges; in-flight reads are forgotten.
  task automatic mid_reset();
    @(posedge vga_clk);
    #3;
    reset_n  = 1'b0;
    req      = '0;
    req_lock = '0;
    #1;
    chk("busy_in_reset", 64'(busy), 64'(0));
    chk("rd_valid_in_reset", 64'(rd_valid), 64'(0));
    chk("gnt_in_reset", 64'(gnt), 64'(0));
    exp_q.delete();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    @(posedge vga_clk);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) addr[i] = '0;
    pend = '0;
    repeat (3) @(posedge vga_clk);
    #2;
    reset_n = 1'b1;

    // Idle: no grants, no reads.
    repeat (20) step('0, '0, g);

    // All requesting, no locks: plain rotation.
    for (int i = 0; i < N; i++) addr[i] = AW'(16 * i);
    repeat (8) step(4'b1111, 4'b0000, g);

    // Requester 0 locks permanently against requester 1.
    repeat (20) step(4'b0011, 4'b0001, g);
    step(4'b0000, 4'b0000, g);

    // Requester 2 bursts then drops req while 3 waits.
    step(4'b0100, 4'b0100, g);
    repeat (2) step(4'b1100, 4'b0100, g);
    repeat (2) step(4'b1000, 4'b0000, g);

    // Alternating requesters, back-to-back returns.
    repeat (12) step(4'b0101, 4'b0000, g);

    // Reset during a burst with reads in flight, then restart from pointer 0.
    repeat (3) step(4'b0001, 4'b0001, g);
    mid_reset();
    repeat (4) step(4'b1111, 4'b0000, g);

    // Randomized traffic: requesters hold req and address until granted.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(3) == 0) begin
            pend[i] = 1'b1;
            addr[i] = AW'($urandom);
          end else if ($urandom_range(1) == 0) begin
            addr[i] = AW'($urandom);
          end
        end
        lk[i] = ($urandom_range(2) != 0);
      end
      step(pend, lk, g);
      if (g >= 0) begin
        addr[g] = addr[g] + AW'(1);
        pend[g] = ($urandom_range(4) != 0);
      end
    end

    repeat (LAT + 2) step('0, '0, g);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
